// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_seq_ctrl
// Purpose  : Sequencer for the 4x4 systolic matmul path. It loads A (row-major)
//            and B (column-major) from the MM2S stream, clears the array, feeds
//            skewed rows/columns into the PE edges, buffers the 16 result words
//            in a FWFT FIFO and returns them on the S2MM stream with TLAST on
//            the 16th word.
// Config   : define SEQ_TIMEOUT_EN to enable the WAIT-state watchdog
//            (TIMEOUT_CYC cycles without a result word aborts the frame).
// Ports    :
//   i_clk, i_rst        clock, synchronous active-low reset
//   i_s_t* / o_s_tready MM2S operand stream (32 beats per frame)
//   o_m_t* / i_m_tready S2MM result stream (16 beats per frame)
//   o_arr_rst           array/accumulate-buffer reset, active-low
//   o_a_*, o_b_*        skewed row/column operand lanes into the array
//   i_res_*             result words from the accumulate buffer
//   o_busy              sequencer is not idle
//   o_err, i_err_clr    sticky {timeout, stray result, framing} flags / clear
// Revision : 1.0 - initial release
// ============================================================================
module systolic_seq_ctrl #(
   parameter int DATA_W      = 32,
   parameter int N           = 4,     // only 4 is supported
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [DATA_W-1:0]   i_s_tdata,
   input  logic                i_s_tvalid,
   input  logic                i_s_tlast,
   output logic                o_s_tready,
   output logic [DATA_W-1:0]   o_m_tdata,
   output logic                o_m_tvalid,
   output logic                o_m_tlast,
   input  logic                i_m_tready,
   output logic                o_arr_rst,
   output logic [N*DATA_W-1:0] o_a_data,
   output logic [N-1:0]        o_a_valid,
   output logic [N*DATA_W-1:0] o_b_data,
   output logic [N-1:0]        o_b_valid,
   input  logic [DATA_W-1:0]   i_res_data,
   input  logic                i_res_valid,
   output logic                o_busy,
   output logic [2:0]          o_err,
   input  logic                i_err_clr
);

   localparam int FIFO_D = N * N;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FEED = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   // Operand storage, result FIFO and counters
   logic [DATA_W-1:0] a_mem    [N][N];
   logic [DATA_W-1:0] b_mem    [N][N];
   logic [DATA_W-1:0] fifo_mem [FIFO_D];

   logic       run;          // 0 for the first cycle after reset: keeps outputs at reset values
   logic       arr_rst_q;
   logic [4:0] beat_cnt;
   logic [2:0] feed_t;
   logic [3:0] wr_ptr;
   logic [3:0] rd_ptr;
   logic [4:0] fifo_cnt;
   logic [3:0] res_cnt;
   logic       res_full;     // all 16 results received; res_cnt holds at 15
   logic [3:0] out_cnt;
   logic [2:0] err;

   logic       s_ready;
   logic       s_hs;
   logic       m_valid;
   logic       m_hs;
   logic       push;
   logic       stray;
   logic       frame_err;
   logic       clr_array;
   logic       timeout;
   logic       leave_wait;

   assign s_ready    = run && ((state == ST_IDLE) || (state == ST_LOAD));
   assign s_hs       = i_s_tvalid && s_ready;
   assign m_valid    = (fifo_cnt != 5'd0);
   assign m_hs       = m_valid && i_m_tready;
   assign push       = (state == ST_WAIT) && i_res_valid && !res_full;
   assign stray      = i_res_valid && !push;
   assign leave_wait = (state == ST_WAIT) && (state_nxt != ST_WAIT);

   // ------------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------------
`ifdef SEQ_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt;

   // Only armed while results are still missing; once all 16 are in, the
   // frame completes at the rate the S2MM sink allows.
   assign timeout = (state == ST_WAIT) && !res_full && (to_cnt == TO_W'(TIMEOUT_CYC));

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         to_cnt <= '0;
      end else if ((state != ST_WAIT) || i_res_valid) begin
         to_cnt <= '0;
      end else if (!res_full && !timeout) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end
`else
   logic unused_timeout_cfg;
   assign timeout            = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and frame-level strobes
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      frame_err = 1'b0;
      clr_array = 1'b0;
      case (state)
         ST_IDLE: begin
            if (s_hs) begin
               // A one-beat frame cannot be valid.
               if (i_s_tlast) begin
                  frame_err = 1'b1;
               end else begin
                  state_nxt = ST_LOAD;
                  clr_array = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            if (s_hs) begin
               if (beat_cnt == 5'd31) begin
                  if (i_s_tlast) begin
                     state_nxt = ST_FEED;
                  end else begin
                     frame_err = 1'b1;
                     state_nxt = ST_IDLE;
                  end
               end else if (i_s_tlast) begin
                  frame_err = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_FEED: begin
            if (feed_t == 3'd6) begin
               state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (timeout) begin
               state_nxt = ST_IDLE;
               clr_array = 1'b1;
            end else if (m_hs && (out_cnt == 4'd15)) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Counters, FIFO pointers and sticky errors
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         run       <= 1'b0;
         arr_rst_q <= 1'b0;
         beat_cnt  <= 5'd0;
         feed_t    <= 3'd0;
         wr_ptr    <= 4'd0;
         rd_ptr    <= 4'd0;
         fifo_cnt  <= 5'd0;
         res_cnt   <= 4'd0;
         res_full  <= 1'b0;
         out_cnt   <= 4'd0;
         err       <= 3'd0;
      end else begin
         run       <= 1'b1;
         arr_rst_q <= !clr_array;
         // A new set in the same cycle as a clear takes priority.
         err       <= (err & ~{3{i_err_clr}}) | {timeout, stray, frame_err};

         if (s_hs && (state_nxt == ST_LOAD)) begin
            beat_cnt <= beat_cnt + 5'd1;
         end else if (state_nxt != ST_LOAD) begin
            beat_cnt <= 5'd0;
         end

         if ((state == ST_FEED) && (feed_t != 3'd6)) begin
            feed_t <= feed_t + 3'd1;
         end else begin
            feed_t <= 3'd0;
         end

         // Leaving WAIT (normal end or watchdog) also flushes the FIFO.
         if (leave_wait) begin
            wr_ptr   <= 4'd0;
            rd_ptr   <= 4'd0;
            fifo_cnt <= 5'd0;
            res_cnt  <= 4'd0;
            res_full <= 1'b0;
            out_cnt  <= 4'd0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + 4'd1;
               if (res_cnt == 4'd15) begin
                  res_full <= 1'b1;
               end else begin
                  res_cnt <= res_cnt + 4'd1;
               end
            end
            if (m_hs) begin
               rd_ptr  <= rd_ptr + 4'd1;
               out_cnt <= out_cnt + 4'd1;
            end
            case ({push, m_hs})
               2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
               2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
               default: fifo_cnt <= fifo_cnt;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Storage (no reset needed: contents are only read after being written)
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst && s_hs) begin
         // Beats 0..15 are A row-major, 16..31 are B column-major.
         if (!beat_cnt[4]) begin
            a_mem[beat_cnt[3:2]][beat_cnt[1:0]] <= i_s_tdata;
         end else begin
            b_mem[beat_cnt[1:0]][beat_cnt[3:2]] <= i_s_tdata;
         end
      end
      if (i_rst && push) begin
         fifo_mem[wr_ptr] <= i_res_data;
      end
   end

   // ------------------------------------------------------------------------
   // Skewed edge lanes: lane i carries element (t - i) of its row/column
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [3:0] d;
      logic       v;
      // Negative offsets set bit 3, offsets of N or more set bit 2.
      assign d = {1'b0, feed_t} - 4'(gi);
      assign v = (state == ST_FEED) && (d[3:2] == 2'b00);

      assign o_a_valid[gi]                 = v;
      assign o_b_valid[gi]                 = v;
      assign o_a_data[gi*DATA_W +: DATA_W] = v ? a_mem[gi][d[1:0]] : '0;
      assign o_b_data[gi*DATA_W +: DATA_W] = v ? b_mem[d[1:0]][gi] : '0;
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign o_s_tready = s_ready;
   assign o_m_tvalid = m_valid;
   assign o_m_tdata  = m_valid ? fifo_mem[rd_ptr] : '0;
   assign o_m_tlast  = m_valid && (out_cnt == 4'd15);
   assign o_arr_rst  = arr_rst_q;
   assign o_busy     = (state != ST_IDLE);
   assign o_err      = err;

endmodule
`default_nettype wire
